// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - pipelined RV32I integer ALU functional unit; define ALU_PIPE_MUL_EN to enable opcode 10 (MUL)
module alu_pipe #(
    parameter int XLEN   = 32,
    parameter int PREG_W = 6,
    parameter int ROB_W  = 6,
    parameter int STAGES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [3:0]        alu_op_i,
    input  logic [XLEN-1:0]   op1_i,
    input  logic [XLEN-1:0]   op2_i,
    input  logic [PREG_W-1:0] rd_p_i,
    input  logic [ROB_W-1:0]  rob_tag_i,
    input  logic              flush_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [XLEN-1:0]   result_o,
    output logic [PREG_W-1:0] rd_p_o,
    output logic [ROB_W-1:0]  rob_tag_o
);

    localparam int SH_W = $clog2(XLEN);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SLL  = 4'd5;
    localparam logic [3:0] OP_SRL  = 4'd6;
    localparam logic [3:0] OP_SRA  = 4'd7;
    localparam logic [3:0] OP_SLT  = 4'd8;
    localparam logic [3:0] OP_SLTU = 4'd9;
`ifdef ALU_PIPE_MUL_EN
    localparam logic [3:0] OP_MUL  = 4'd10;
`endif
    localparam logic [3:0] OP_PASS = 4'd11;

    generate
        if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
            $error("alu_pipe: STAGES must be within 1..4");
        end
`ifdef ALU_PIPE_MUL_EN
        // The multiplier needs at least one extra register stage behind it.
        if (STAGES < 2) begin : g_bad_mul_stages
            $error("alu_pipe: ALU_PIPE_MUL_EN requires STAGES >= 2");
        end
`endif
    endgenerate

    logic [SH_W-1:0]   shamt;
    logic [XLEN-1:0]   alu_res;

    logic [STAGES-1:0] stg_valid;
    logic [STAGES-1:0] stg_adv;
    logic              blocked;
    logic              accept;

    logic [XLEN-1:0]   stg_res  [STAGES];
    logic [PREG_W-1:0] stg_rd   [STAGES];
    logic [ROB_W-1:0]  stg_rob  [STAGES];

    // Only the low log2(XLEN) bits of op2 select the shift distance.
    assign shamt = op2_i[SH_W-1:0];

    // Combinational ALU; unknown opcodes fall through to zero.
    always_comb begin
        alu_res = '0;
        case (alu_op_i)
            OP_ADD:  alu_res = op1_i + op2_i;
            OP_SUB:  alu_res = op1_i - op2_i;
            OP_AND:  alu_res = op1_i & op2_i;
            OP_OR:   alu_res = op1_i | op2_i;
            OP_XOR:  alu_res = op1_i ^ op2_i;
            OP_SLL:  alu_res = op1_i << shamt;
            OP_SRL:  alu_res = op1_i >> shamt;
            OP_SRA:  alu_res = $signed(op1_i) >>> shamt;
            OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(op1_i) < $signed(op2_i))};
            OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, (op1_i < op2_i)};
`ifdef ALU_PIPE_MUL_EN
            OP_MUL:  alu_res = op1_i * op2_i;
`endif
            OP_PASS: alu_res = op2_i;
            default: alu_res = '0;
        endcase
    end

    // Stage s advances unless it and every stage after it are full and the CDB is not granting.
    always_comb begin
        stg_adv = '0;
        blocked = !ready_i;
        for (int s = STAGES - 1; s >= 0; s--) begin
            blocked    = blocked & stg_valid[s];
            stg_adv[s] = !blocked;
        end
    end

    assign ready_o   = !stg_valid[0] | stg_adv[0];
    assign accept    = valid_i & ready_o;

    assign valid_o   = stg_valid[STAGES-1] & !flush_i;
    assign result_o  = stg_res[STAGES-1];
    assign rd_p_o    = stg_rd[STAGES-1];
    assign rob_tag_o = stg_rob[STAGES-1];

    // Stage valid bits: reset and flush empty the whole pipe, otherwise shift where advancing.
    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            stg_valid <= '0;
        end else begin
            if (stg_adv[0]) begin
                stg_valid[0] <= accept;
            end
            for (int s = 1; s < STAGES; s++) begin
                if (stg_adv[s]) begin
                    stg_valid[s] <= stg_valid[s-1];
                end
            end
        end
    end

    // Payload registers are unreset and load only when their stage takes a valid entry.
    always_ff @(posedge clk) begin
        if (accept && !flush_i && !rst) begin
            stg_res[0] <= alu_res;
            stg_rd[0]  <= rd_p_i;
            stg_rob[0] <= rob_tag_i;
        end
        for (int s = 1; s < STAGES; s++) begin
            if (stg_adv[s] && stg_valid[s-1]) begin
                stg_res[s] <= stg_res[s-1];
                stg_rd[s]  <= stg_rd[s-1];
                stg_rob[s] <= stg_rob[s-1];
            end
        end
    end

endmodule

// File: doc/alu_pipe.md
# alu_pipe

Parametrised, pipelined integer ALU functional unit for the out-of-order core. It accepts one issued micro-op per cycle from the issue queue and computes a full RV32I register/immediate ALU operation set. It delivers the result, physical destination tag and ROB tag to the CDB arbiter after a configurable number of stages. Full valid/ready backpressure and a pipeline-wide flush for mispredict recovery are supported.

## Interface
- XLEN, 32: operand/result width (32 or 64).
- PREG_W, 6: physical register tag width.
- ROB_W, 6: ROB tag width.
- STAGES, 1: pipeline depth, legal range 1..4.

- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- valid_i  in  1  issue presents a micro-op.
- ready_o  out  1  unit accepts the micro-op this cycle.
- alu_op_i  in  4  operation code.
- op1_i, op2_i  in  XLEN  operands (op2 already muxed with immediate).
- rd_p_i  in  PREG_W  destination physical register.
- rob_tag_i  in  ROB_W  ROB entry tag.
- flush_i  in  1  kill all in-flight and incoming ops.
- valid_o  out  1  result available to CDB.
- ready_i  in  1  CDB arbiter grants this unit.
- result_o  out  XLEN  result.
- rd_p_o  out  PREG_W  destination tag.
- rob_tag_o  out  ROB_W  ROB tag.

## Operation
- Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT (signed), 9 SLTU, 10 MUL (macro only), 11 PASS (op2, for LUI). All other codes produce 0, and the op still completes normally.
- Shift amount is op2[log2(XLEN)-1:0]; upper bits are ignored. SLT and SLTU return 1 or 0, zero-extended. Arithmetic wraps modulo 2^XLEN.
- The result is computed combinationally from the inputs and captured in stage 0. Stages 1..STAGES-1 are pure delay registers carrying {valid, result, rd_p, rob_tag}.
- Each stage s advances when it is empty or stage s+1 advances. The last stage advances on ready_i or when it is empty. This allows bubble collapse: an empty stage always accepts.
- ready_o = !valid[0] | advance[0], a combinational chain from ready_i.
- An input is accepted when valid_i & ready_o.
- Stall: when a stage does not advance, its contents are held unchanged.
- Payload registers load only when their stage loads a valid entry. Payload outputs are don't-care while valid_o=0.
- Flush: flush_i clears every stage valid bit at the edge. An input presented in the same cycle is dropped. valid_o = last_valid & !flush_i, so no output handshake completes in a flush cycle. ready_o is not affected by flush_i.
- Flush and reset take priority over every other event.

## Timing
- Reset: all stage valids = 0, so valid_o=0 and ready_o=1 on the first cycle after reset. Payload outputs are not reset.
- Latency: an op accepted at edge k shows valid_o=1 in the cycle following edge k+STAGES-1. With STAGES=1, the result appears the cycle after acceptance.
- Throughput: one op per cycle while ready_i stays high.
- Capacity: STAGES ops in flight. With ready_i held low, ready_o falls after STAGES accepts. Raising ready_i re-enables ready_o in the same cycle.
- Reset mid-operation discards all in-flight ops; none appear on the output afterwards.
- valid_o, once high, stays high with stable payload until ready_i or flush_i.

## Configuration
- ALU_PIPE_MUL_EN defined: opcode 10 returns the low XLEN bits of op1*op2 (sign-agnostic). The multiply is computed in stage 0, and STAGES ≥ 2 is required; STAGES=1 triggers an elaboration error.
- ALU_PIPE_MUL_EN undefined: opcode 10 returns 0, and no multiplier is inferred.

## Test plan
- STAGES=2, ready_i=1, back-to-back ADD 5+7 then SUB 3-5 -> valid_o high 2 and 3 cycles after the first accept; results 12 then 0xFFFFFFFE, with tags preserved.
- SRA 0x80000000 by 4 -> 0xF8000000. SLT 0xFFFFFFFF,1 -> 1. SLTU on the same operands -> 0. SLL by 33 (XLEN=32) -> shifts by 1.
- STAGES=3, ready_i=0, 4 ops offered -> 3 accepted and ready_o=0. Raise ready_i -> results drain in order, one per cycle, and the 4th op is accepted in that same cycle.
- 2 ops in flight, flush_i pulsed alongside a new valid_i -> valid_o stays 0 for the next 4 cycles. The next op after flush completes normally.
- rst asserted with a full pipeline -> valid_o=0 and ready_o=1 the next cycle, with no stale output afterwards.
- With ALU_PIPE_MUL_EN, STAGES=2, MUL 0x10000*0x10001 -> 0x00010000. Without the macro -> 0.
